uart_rx: RTL and testbench

UART receiver with 16x oversampling. It recovers serial frames from the rx line: 1 start bit, DBIT data bits LSB first, and 1 stop bit of SB_TICK ticks. It presents each received byte with a one-cycle done strobe and a framing-error flag. It sits between the shared baud-rate tick generator and the MIPS debug/host unit, as the receive half of the board's serial link.

---
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: 1 start bit, DBIT data bits LSB first, and a
// stop bit spanning SB_TICK ticks. Each frame ends in a one-cycle strobe with a framing flag.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       busy
);

    // The tick counter must reach SB_TICK-1 in the stop state, so it grows past 4 bits for long stops.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [SW-1:0]   s;
    logic [2:0]      n;
    logic [DBIT-1:0] b;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            data_out     <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    // Half a bit in: a line that has gone high again was only a glitch.
                    if (s_tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == SW'(15)) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == 3'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + 3'd1;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            data_out     <= 8'(b);
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a default instance (8N1) and a DBIT=7/SB_TICK=32
// instance, driven by tick-aligned serial frames and checked by independent monitors.
module tb_uart_rx;

    localparam int D0 = 8;
    localparam int S0 = 16;
    localparam int D1 = 7;
    localparam int S1 = 32;

    typedef struct packed {
        logic [7:0]  data;
        logic        ferr;
        logic [15:0] lat;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx0    = 1'b1;
    logic       rx1    = 1'b1;
    logic [7:0] data0, data1;
    logic       done0, done1, ferr0, ferr1, busy0, busy1;

    exp_t exp0_q[$];
    exp_t exp1_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   tick_div   = 16;
    int   div_cnt    = 0;
    int   tick_count = 0;
    int   start0     = 0;
    int   start1     = 0;
    int   sent0      = 0;
    int   sent1      = 0;
    int   strobes0   = 0;
    int   strobes1   = 0;

    uart_rx dut0 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx0),
        .data_out     (data0),
        .rx_done_tick (done0),
        .frame_err    (ferr0),
        .busy         (busy0)
    );

    uart_rx #(.DBIT(D1), .SB_TICK(S1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx1),
        .data_out     (data1),
        .rx_done_tick (done1),
        .frame_err    (ferr1),
        .busy         (busy1)
    );

    // Clock and oversampling tick generator
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_cnt >= tick_div - 1) begin
            div_cnt    <= 0;
            s_tick     <= 1'b1;
            tick_count <= tick_count + 1;
        end else begin
            div_cnt <= div_cnt + 1;
            s_tick  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Each call consumes n ticks and returns on the falling edge inside the last tick cycle.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(negedge clk); while (s_tick !== 1'b1);
        end
    endtask

    task automatic drive_bit(input int port, input logic v, input int n);
        if (port == 0) rx0 = v;
        else rx1 = v;
        wait_ticks(n);
    endtask

    // Reference model: the word is the low DBIT bits, the flag is the inverted stop level, and the
    // strobe lands 8 ticks (mid start bit) + 16 per data bit + the stop span after the start edge.
    task automatic send_frame(input int port, input logic [7:0] data, input logic stop_ok, input int gap);
        int   dbit = (port == 0) ? D0 : D1;
        int   sb   = (port == 0) ? S0 : S1;
        exp_t e;
        e.data = 8'(data & 8'((1 << dbit) - 1));
        e.ferr = ~stop_ok;
        e.lat  = 16'(8 + 16 * dbit + sb);
        if (port == 0) begin
            exp0_q.push_back(e);
            sent0++;
            start0 = tick_count;
        end else begin
            exp1_q.push_back(e);
            sent1++;
            start1 = tick_count;
        end
        drive_bit(port, 1'b0, 16);
        for (int i = 0; i < dbit; i++) drive_bit(port, data[i], 16);
        if (stop_ok) begin
            drive_bit(port, 1'b1, sb);
        end else begin
            drive_bit(port, 1'b0, 10);
            drive_bit(port, 1'b1, sb - 10);
        end
        if (gap > 0) drive_bit(port, 1'b1, gap);
    endtask

    // Monitors
    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0 === 1'b1) begin
            strobes0++;
            if (exp0_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_strobe: got data 0x%0h, required no strobe", data0);
            end else begin
                e = exp0_q.pop_front();
                check("dut0_data", 32'(data0), 32'(e.data));
                check("dut0_frame_err", 32'(ferr0), 32'(e.ferr));
                check("dut0_latency_ticks", 32'(tick_count - start0), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            strobes1++;
            if (exp1_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_strobe: got data 0x%0h, required no strobe", data1);
            end else begin
                e = exp1_q.pop_front();
                check("dut1_data", 32'(data1), 32'(e.data));
                check("dut1_frame_err", 32'(ferr1), 32'(e.ferr));
                check("dut1_latency_ticks", 32'(tick_count - start1), 32'(e.lat));
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       ok;
        int         gap;

        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data_out", 32'(data0), 0);
        check("reset_done", 32'(done0), 0);
        check("reset_frame_err", 32'(ferr0), 0);
        check("reset_busy", 32'(busy0), 0);
        check("reset_dut1_data_out", 32'(data1), 0);
        reset = 1'b1;
        wait_ticks(2);

        send_frame(0, 8'hA5, 1'b1, 2);
        check("busy_after_a5", 32'(busy0), 0);
        check("strobes_after_a5", 32'(strobes0), 1);

        // Start-bit glitch: three ticks low, then high again
        rx0 = 1'b0;
        wait_ticks(2);
        check("busy_in_glitch", 32'(busy0), 1);
        wait_ticks(1);
        rx0 = 1'b1;
        wait_ticks(12);
        check("busy_after_glitch", 32'(busy0), 0);
        check("data_held_after_glitch", 32'(data0), 32'h0A5);
        check("strobes_after_glitch", 32'(strobes0), 1);

        send_frame(0, 8'h3C, 1'b0, 6);
        send_frame(0, 8'h81, 1'b1, 2);
        send_frame(0, 8'h00, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b1, 2);
        check("strobes_after_b2b", 32'(strobes0), 5);

        // Reset in the middle of data bit 4 of 0xF0
        d = 8'hF0;
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], 16);
        drive_bit(0, d[4], 8);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_data_out", 32'(data0), 0);
        check("midreset_done", 32'(done0), 0);
        check("midreset_frame_err", 32'(ferr0), 0);
        check("midreset_busy", 32'(busy0), 0);
        rx0 = 1'b1;
        wait_ticks(2);
        reset = 1'b1;
        wait_ticks(20);
        check("busy_after_abort", 32'(busy0), 0);
        check("strobes_after_abort", 32'(strobes0), 5);
        send_frame(0, 8'h5A, 1'b1, 2);

        // Randomized frames at a faster tick rate
        tick_div = 4;
        wait_ticks(2);
        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 3) != 0);
            gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 8));
            send_frame(0, d, ok, gap);
        end

        send_frame(1, 8'h55, 1'b1, 2);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(1, d, 1'b1, int'($urandom_range(0, 3)));
        end

        for (int c = 0; c < 2000 && (exp0_q.size() != 0 || exp1_q.size() != 0); c++) @(negedge clk);
        check("dut0_queue_drained", 32'(exp0_q.size()), 0);
        check("dut1_queue_drained", 32'(exp1_q.size()), 0);
        check("dut0_strobe_count", 32'(strobes0), 32'(sent0));
        check("dut1_strobe_count", 32'(strobes1), 32'(sent1));
        check("dut0_busy_end", 32'(busy0), 0);
        check("dut1_busy_end", 32'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
